snake_body_tracker: RTL and testbench
=====================================

# snake_body_tracker

Downstream consumer of the navigation state machine's direction output. Converts the 2-bit direction into timed head movement on a wrapping grid, keeps a shift-register snake body of up to `MAX_LEN` segments, handles growth and self-collision, and answers per-pixel "is this cell snake?" queries for the VGA colour stage.

## Interface
- `X_MAX`, 160, grid width in cells.
- `Y_MAX`, 120, grid height in cells.
- `XW`, 8, X coordinate width, ≥ clog2(X_MAX).
- `YW`, 7, Y coordinate width, ≥ clog2(Y_MAX).
- `MAX_LEN`, 16, segment capacity.
- `INIT_LEN`, 4, length after reset, 2..MAX_LEN.
- `TICK_DIV`, 5_000_000, clock cycles per move, ≥ 2.
- `CLK`  in  1  system clock; single clock domain.
- `RESET`  in  1  synchronous, active-high reset.
- `NSM_state`  in  2  requested direction: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT.
- `EN`  in  1  movement enable; low freezes the tick counter.
- `GROW`  in  1  one-cycle pulse: lengthen by one at the next move.
- `ADDR_X`  in  XW  query cell X.
- `ADDR_Y`  in  YW  query cell Y.
- `IS_HEAD`  out  1  query cell equals head (registered).
- `IS_BODY`  out  1  query cell equals an active non-head segment (registered).
- `HEAD_X`  out  XW  current head X.
- `HEAD_Y`  out  YW  current head Y.
- `LENGTH`  out  clog2(MAX_LEN+1)  active segment count.
- `MOVE_TICK`  out  1  one-cycle pulse on each move edge.
- `SELF_HIT`  out  1  sticky collision flag.

## Operation
- Reset: head `(X_MAX/2, Y_MAX/2)`, direction RIGHT, `LENGTH=INIT_LEN`, `seg[i]=(X_MAX/2-i, Y_MAX/2)` for all i; counter 0; `MOVE_TICK=0`, `SELF_HIT=0`, `IS_HEAD=0`, `IS_BODY=0`.
- Tick counter: increments while `EN=1 && SELF_HIT=0`; at `TICK_DIV-1` it wraps to 0 and a move occurs on that edge.
- Direction: sampled only at a move. A request exactly opposite the current direction is ignored; the current direction is kept.
- Step: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1. Wrap: x=X_MAX-1 +1→0, x=0 -1→X_MAX-1; same for y with Y_MAX.
- Collision: candidate head is compared against old `seg[0..LENGTH-2]`. On a match, no shift occurs, `SELF_HIT` is set and held until `RESET`, and all movement stops.
- Otherwise: `seg[i]<=seg[i-1]`, `seg[0]<=candidate`. If growth is pending, `LENGTH<=LENGTH+1`, saturating at `MAX_LEN`, and the pending flag clears.
- `GROW` sets the pending flag. Multiple pulses between moves count as one. A pulse coincident with a move edge applies to that move.
- Query: `IS_HEAD`/`IS_BODY` are registered compares of `ADDR_X/ADDR_Y` against `seg[0]` and `seg[1..LENGTH-1]`. Segments at index ≥ LENGTH never match.

## Timing
- First `MOVE_TICK` is `TICK_DIV` cycles after the last `RESET` cycle with `EN` held high. Subsequent ticks are every `TICK_DIV` enabled cycles.
- `HEAD_X/HEAD_Y`, `LENGTH`, `seg[]` and `SELF_HIT` update on the same edge that raises `MOVE_TICK`.
- Query latency is 1 cycle, with a fully pipelined lookup that accepts a new address every cycle.
- A `RESET` mid-move, or while `SELF_HIT` is set, restores all reset values on the next edge and discards any pending growth.
- Deasserting `EN` holds the counter value. Movement resumes from that count.

## Structure
- Shared package `snake_pkg`: direction localparams `DIR_UP/RIGHT/DOWN/LEFT`, grid defaults `X_MAX/Y_MAX`, and the `opposite(dir)` function, which is also used by the NSM.
- One sub-module: `snake_move_timer`, containing the tick counter and `EN` gating and producing the move strobe. Segment storage, collision logic and query logic stay in the top.

## Test plan
All scenarios use `X_MAX=8`, `Y_MAX=8`, `INIT_LEN=3`, `MAX_LEN=5`, `TICK_DIV=4`. Reset state is head `(4,4)`, body `(3,4),(2,4)`.
- Reset, `EN=1`, `NSM_state=1` → `MOVE_TICK` on cycle 4; head (5,4), then (6,4), (7,4), then (0,4) (wrap); `LENGTH=3` throughout.
- Moving RIGHT, drive `NSM_state=3` (LEFT) → reversal ignored; head continues to advance by +1 per tick.
- Drive `NSM_state=0` from (4,0) → next head (4,7) (Y wrap). DOWN from (4,7) → (4,0).
- Three `GROW` pulses on separate moves → `LENGTH` goes 4, 5, 5 (saturates). Two pulses within one tick period → `LENGTH` goes up by only 1.
- `LENGTH=5` with head (4,4), then RIGHT, UP, LEFT, DOWN → the fourth move hits seg (4,4). `SELF_HIT=1`, head stays at (4,3), and no further `MOVE_TICK` occurs. `RESET` → head (4,4), `SELF_HIT=0`.
- After reset, `ADDR=(3,4)` → `IS_BODY=1` one cycle later. `(4,4)` → `IS_HEAD=1`. `(2,4)` → `IS_BODY=1`. `(1,4)` → both 0.

Source files
------------

// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake game datapath: direction encoding, default
// grid size and the opposite() helper, which is also used by the navigation
// state machine so both blocks agree on what a reversal is.
// ---------------------------------------------------------------------------
package snake_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_RIGHT = 2'd1;
   localparam dir_t DIR_DOWN  = 2'd2;
   localparam dir_t DIR_LEFT  = 2'd3;

   localparam int X_MAX = 160;
   localparam int Y_MAX = 120;

   // The encoding pairs opposites two apart, so flipping bit 1 reverses.
   function automatic dir_t opposite(input dir_t dir);
      return dir ^ 2'b10;
   endfunction

endpackage

// File: rtl/snake_body_tracker_if.sv
// ---------------------------------------------------------------------------
// snake_body_tracker_if
// Groups the tracker's control, query and status signals.
//   master : drives NSM_state, EN, GROW, ADDR_X, ADDR_Y; reads the status
//   slave  : the tracker itself
// Status: IS_HEAD, IS_BODY, HEAD_X, HEAD_Y, LENGTH, MOVE_TICK, SELF_HIT.
// ---------------------------------------------------------------------------
interface snake_body_tracker_if #(
   parameter int XW = 8,
   parameter int YW = 7,
   parameter int LW = 5
);
   logic [1:0]    NSM_state;
   logic          EN;
   logic          GROW;
   logic [XW-1:0] ADDR_X;
   logic [YW-1:0] ADDR_Y;
   logic          IS_HEAD;
   logic          IS_BODY;
   logic [XW-1:0] HEAD_X;
   logic [YW-1:0] HEAD_Y;
   logic [LW-1:0] LENGTH;
   logic          MOVE_TICK;
   logic          SELF_HIT;

   modport master (
      output NSM_state, EN, GROW, ADDR_X, ADDR_Y,
      input  IS_HEAD, IS_BODY, HEAD_X, HEAD_Y, LENGTH, MOVE_TICK, SELF_HIT
   );

   modport slave (
      input  NSM_state, EN, GROW, ADDR_X, ADDR_Y,
      output IS_HEAD, IS_BODY, HEAD_X, HEAD_Y, LENGTH, MOVE_TICK, SELF_HIT
   );
endinterface

// File: rtl/snake_move_timer.sv
// ---------------------------------------------------------------------------
// snake_move_timer
// Divides the system clock down to the snake's move rate.
//   clk      : system clock
//   rst      : synchronous active-high reset, clears the count
//   en       : movement enable; low holds the count where it is
//   halt     : freezes the counter for good (collision)
//   move_now : high during the cycle whose closing edge is a move edge
// ---------------------------------------------------------------------------
module snake_move_timer #(
   parameter int TICK_DIV = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic halt,
   output logic move_now
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] count;
   logic          run;

   assign run      = en && !halt;
   assign move_now = run && (count == CW'(TICK_DIV - 1));

   // Count enabled cycles; the terminal count wraps to zero on the move edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (move_now) begin
         count <= '0;
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/snake_body_tracker.sv
// ---------------------------------------------------------------------------
// snake_body_tracker
// Turns the navigation direction into timed head movement on a wrapping grid,
// keeps the snake body as a shift register of segments, handles growth and
// self-collision, and answers per-cell "is this snake?" queries for VGA.
//   CLK   : system clock
//   RESET : synchronous active-high reset
//   trk   : slave side of snake_body_tracker_if (direction, enable, grow,
//           query address in; head/body hits, head position, length,
//           move tick and sticky self-hit out)
// ---------------------------------------------------------------------------
module snake_body_tracker #(
   parameter int X_MAX    = snake_pkg::X_MAX,
   parameter int Y_MAX    = snake_pkg::Y_MAX,
   parameter int XW       = 8,
   parameter int YW       = 7,
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 4,
   parameter int TICK_DIV = 5_000_000,
   localparam int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic                CLK,
   input  logic                RESET,
   snake_body_tracker_if.slave trk
);

   import snake_pkg::*;

   logic [XW-1:0] seg_x [MAX_LEN];
   logic [YW-1:0] seg_y [MAX_LEN];
   dir_t          dir;
   logic [LW-1:0] length;
   logic          grow_pending;
   logic          self_hit;
   logic          move_tick;
   logic          is_head;
   logic          is_body;

   logic          move_now;
   dir_t          next_dir;
   logic [XW-1:0] cand_x;
   logic [YW-1:0] cand_y;
   logic          hit_now;
   logic          query_head;
   logic          query_body;

   // Reset body trails left of the centre; indices past the left edge wrap.
   function automatic logic [XW-1:0] init_x(input int idx);
      int v;
      v = (((X_MAX / 2 - idx) % X_MAX) + X_MAX) % X_MAX;
      return XW'(v);
   endfunction

   snake_move_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk      (CLK),
      .rst      (RESET),
      .en       (trk.EN),
      .halt     (self_hit),
      .move_now (move_now)
   );

   // Candidate head for the next move. The old tail-most active segment is
   // excluded from the collision check because it vacates its cell on this
   // same move, so only seg[0..LENGTH-2] can block the head.
   always_comb begin
      next_dir = (trk.NSM_state == opposite(dir)) ? dir : trk.NSM_state;
      cand_x   = seg_x[0];
      cand_y   = seg_y[0];
      case (next_dir)
         DIR_UP:    cand_y = (seg_y[0] == '0) ? YW'(Y_MAX - 1) : seg_y[0] - 1'b1;
         DIR_RIGHT: cand_x = (seg_x[0] == XW'(X_MAX - 1)) ? '0 : seg_x[0] + 1'b1;
         DIR_DOWN:  cand_y = (seg_y[0] == YW'(Y_MAX - 1)) ? '0 : seg_y[0] + 1'b1;
         default:   cand_x = (seg_x[0] == '0) ? XW'(X_MAX - 1) : seg_x[0] - 1'b1;
      endcase
      hit_now = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((i + 2) <= int'(length) && seg_x[i] == cand_x && seg_y[i] == cand_y) begin
            hit_now = 1'b1;
         end
      end
   end

   // Query compare against the current segments; inactive tail entries are
   // masked by LENGTH so stale positions never light up on screen.
   always_comb begin
      query_head = (trk.ADDR_X == seg_x[0]) && (trk.ADDR_Y == seg_y[0]);
      query_body = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if (i < int'(length) && trk.ADDR_X == seg_x[i] && trk.ADDR_Y == seg_y[i]) begin
            query_body = 1'b1;
         end
      end
   end

   // Segment shift register, growth bookkeeping and registered query/status.
   // A GROW pulse on the move edge itself is folded into that move.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= init_x(i);
            seg_y[i] <= YW'(Y_MAX / 2);
         end
         dir          <= DIR_RIGHT;
         length       <= LW'(INIT_LEN);
         grow_pending <= 1'b0;
         self_hit     <= 1'b0;
         move_tick    <= 1'b0;
         is_head      <= 1'b0;
         is_body      <= 1'b0;
      end else begin
         move_tick <= move_now;
         is_head   <= query_head;
         is_body   <= query_body;
         if (move_now) begin
            dir <= next_dir;
            if (hit_now) begin
               self_hit     <= 1'b1;
               grow_pending <= grow_pending | trk.GROW;
            end else begin
               for (int i = 1; i < MAX_LEN; i++) begin
                  seg_x[i] <= seg_x[i-1];
                  seg_y[i] <= seg_y[i-1];
               end
               seg_x[0] <= cand_x;
               seg_y[0] <= cand_y;
               if ((grow_pending || trk.GROW) && length < LW'(MAX_LEN)) begin
                  length <= length + 1'b1;
               end
               grow_pending <= 1'b0;
            end
         end else if (trk.GROW) begin
            grow_pending <= 1'b1;
         end
      end
   end

   assign trk.HEAD_X    = seg_x[0];
   assign trk.HEAD_Y    = seg_y[0];
   assign trk.LENGTH    = length;
   assign trk.MOVE_TICK = move_tick;
   assign trk.SELF_HIT  = self_hit;
   assign trk.IS_HEAD   = is_head;
   assign trk.IS_BODY   = is_body;

endmodule

// File: tb/tb_snake_body_tracker.sv
// ---------------------------------------------------------------------------
// tb_snake_body_tracker
// Self-checking bench for snake_body_tracker on an 8x8 grid, MAX_LEN=5,
// INIT_LEN=3, TICK_DIV=4. A queue-based snake model is compared against the
// DUT every cycle; directed scenarios add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_snake_body_tracker;

   localparam int XM = 8;
   localparam int YM = 8;
   localparam int XW = 3;
   localparam int YW = 3;
   localparam int ML = 5;
   localparam int IL = 3;
   localparam int TD = 4;
   localparam int LW = 3;

   logic clk;
   logic rst;

   snake_body_tracker_if #(.XW(XW), .YW(YW), .LW(LW)) bus ();

   snake_body_tracker #(
      .X_MAX    (XM),
      .Y_MAX    (YM),
      .XW       (XW),
      .YW       (YW),
      .MAX_LEN  (ML),
      .INIT_LEN (IL),
      .TICK_DIV (TD)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .trk   (bus)
   );

   int compared   = 0;
   int mismatched = 0;
   int sweep      = 0;

   // Model: cells encoded as x*256+y, head first, MAX_LEN entries kept.
   int body [$];
   int m_dir;
   int m_len;
   int m_cnt;
   bit m_pend;
   bit m_hit;
   bit m_tick;
   bit m_ih;
   bit m_ib;
   bit model_valid = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelStep();
      int a;
      int hx;
      int hy;
      int nd;
      int cand;
      bit coll;
      if (rst) begin
         body.delete();
         for (int i = 0; i < ML; i++) begin
            body.push_back(((((XM / 2 - i) % XM) + XM) % XM) * 256 + YM / 2);
         end
         m_dir = 1; m_len = IL; m_cnt = 0; m_pend = 0; m_hit = 0;
         m_tick = 0; m_ih = 0; m_ib = 0;
         model_valid = 1'b1;
         return;
      end
      if (!model_valid) return;
      a = int'(bus.ADDR_X) * 256 + int'(bus.ADDR_Y);
      m_ih = (body[0] == a);
      m_ib = 0;
      for (int i = 1; i < m_len; i++) if (body[i] == a) m_ib = 1;
      m_tick = 0;
      if (bus.GROW) m_pend = 1;
      if (bus.EN && !m_hit) begin
         if (m_cnt == TD - 1) begin
            m_cnt  = 0;
            m_tick = 1;
            nd = int'(bus.NSM_state);
            if (nd == (m_dir + 2) % 4) nd = m_dir;
            m_dir = nd;
            hx = body[0] / 256;
            hy = body[0] % 256;
            case (nd)
               0: hy = (hy + YM - 1) % YM;
               1: hx = (hx + 1) % XM;
               2: hy = (hy + 1) % YM;
               default: hx = (hx + XM - 1) % XM;
            endcase
            cand = hx * 256 + hy;
            coll = 0;
            for (int i = 0; i <= m_len - 2; i++) if (body[i] == cand) coll = 1;
            if (coll) begin
               m_hit = 1;
            end else begin
               body.push_front(cand);
               void'(body.pop_back());
               if (m_pend) begin
                  if (m_len < ML) m_len++;
                  m_pend = 0;
               end
            end
         end else begin
            m_cnt++;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         modelStep();
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (model_valid) begin
            checkOutput("cmp_head_x", 32'(bus.HEAD_X), body[0] / 256);
            checkOutput("cmp_head_y", 32'(bus.HEAD_Y), body[0] % 256);
            checkOutput("cmp_length", 32'(bus.LENGTH), m_len);
            checkOutput("cmp_move_tick", 32'(bus.MOVE_TICK), 32'(m_tick));
            checkOutput("cmp_self_hit", 32'(bus.SELF_HIT), 32'(m_hit));
            checkOutput("cmp_is_head", 32'(bus.IS_HEAD), 32'(m_ih));
            checkOutput("cmp_is_body", 32'(bus.IS_BODY), 32'(m_ib));
         end
      end
   end

   task automatic applyStimulus(input int dir, input bit en, input bit grow);
      bus.NSM_state = 2'(dir);
      bus.EN        = en;
      bus.GROW      = grow;
   endtask

   // Advance one cycle, then sweep the query address across the grid.
   task automatic stepCycle();
      @(negedge clk);
      bus.ADDR_X = XW'(sweep % 8);
      bus.ADDR_Y = YW'((sweep / 8) % 8);
      sweep++;
   endtask

   task automatic waitTick(output int cycles);
      cycles = 0;
      for (int k = 0; k < 40; k++) begin
         stepCycle();
         cycles++;
         if (bus.MOVE_TICK === 1'b1) return;
      end
      checkOutput("tick_timeout", 0, 1);
   endtask

   task automatic checkHead(input string name, input int x, input int y, input int len);
      checkOutput({name, "_x"}, 32'(bus.HEAD_X), x);
      checkOutput({name, "_y"}, 32'(bus.HEAD_Y), y);
      checkOutput({name, "_len"}, 32'(bus.LENGTH), len);
   endtask

   task automatic queryCheck(input int ax, input int ay, input bit eh, input bit eb);
      bus.ADDR_X = XW'(ax);
      bus.ADDR_Y = YW'(ay);
      @(negedge clk);
      checkOutput("query_is_head", 32'(bus.IS_HEAD), 32'(eh));
      checkOutput("query_is_body", 32'(bus.IS_BODY), 32'(eb));
   endtask

   initial begin
      int c;
      int ticks;
      rst = 1'b1;
      applyStimulus(1, 0, 0);
      bus.ADDR_X = '0;
      bus.ADDR_Y = '0;
      repeat (2) @(negedge clk);
      checkHead("reset_head", 4, 4, 3);
      checkOutput("reset_self_hit", 32'(bus.SELF_HIT), 0);
      checkOutput("reset_move_tick", 32'(bus.MOVE_TICK), 0);
      checkOutput("reset_is_head", 32'(bus.IS_HEAD), 0);
      checkOutput("reset_is_body", 32'(bus.IS_BODY), 0);

      // Straight run right with X wrap.
      rst = 1'b0;
      applyStimulus(1, 1, 0);
      waitTick(c);
      checkOutput("first_tick_latency", c, 4);
      checkHead("move1", 5, 4, 3);
      waitTick(c); checkHead("move2", 6, 4, 3);
      waitTick(c); checkHead("move3", 7, 4, 3);
      waitTick(c); checkHead("x_wrap", 0, 4, 3);

      // Reversal ignored, then an enable gap mid-period.
      applyStimulus(3, 1, 0);
      waitTick(c); checkHead("reversal_ignored", 1, 4, 3);
      stepCycle(); stepCycle();
      bus.EN = 1'b0;
      repeat (3) stepCycle();
      bus.EN = 1'b1;
      waitTick(c);
      checkOutput("resume_after_freeze", c, 2);
      checkHead("after_freeze", 2, 4, 3);

      // Up through the top edge, then down through the bottom edge.
      applyStimulus(1, 1, 0);
      waitTick(c); waitTick(c); checkHead("to_centre", 4, 4, 3);
      applyStimulus(0, 1, 0);
      repeat (4) waitTick(c);
      checkHead("at_top", 4, 0, 3);
      waitTick(c); checkHead("y_wrap_up", 4, 7, 3);
      applyStimulus(1, 1, 0);
      waitTick(c); checkHead("turn_right", 5, 7, 3);
      applyStimulus(2, 1, 0);
      waitTick(c); checkHead("y_wrap_down", 5, 0, 3);

      // Two GROW pulses inside one period count once.
      bus.GROW = 1'b1; stepCycle();
      bus.GROW = 1'b0; stepCycle();
      bus.GROW = 1'b1; stepCycle();
      bus.GROW = 1'b0;
      waitTick(c); checkHead("double_grow", 5, 1, 4);
      waitTick(c); checkHead("double_grow_once", 5, 2, 4);

      // Reset mid-run, then grow on three separate moves.
      rst = 1'b1;
      stepCycle();
      checkHead("mid_reset", 4, 4, 3);
      checkOutput("mid_reset_tick", 32'(bus.MOVE_TICK), 0);
      rst = 1'b0;
      applyStimulus(1, 1, 1); stepCycle(); bus.GROW = 1'b0;
      waitTick(c); checkHead("grow1", 5, 4, 4);
      bus.GROW = 1'b1; stepCycle(); bus.GROW = 1'b0;
      waitTick(c); checkHead("grow2", 6, 4, 5);
      bus.GROW = 1'b1; stepCycle(); bus.GROW = 1'b0;
      waitTick(c); checkHead("grow_saturate", 7, 4, 5);
      repeat (5) waitTick(c);
      checkHead("long_at_centre", 4, 4, 5);

      // Square loop into own body.
      applyStimulus(1, 1, 0); waitTick(c); checkHead("loop_r", 5, 4, 5);
      applyStimulus(0, 1, 0); waitTick(c); checkHead("loop_u", 5, 3, 5);
      applyStimulus(3, 1, 0); waitTick(c); checkHead("loop_l", 4, 3, 5);
      applyStimulus(2, 1, 0); waitTick(c);
      checkOutput("self_hit_set", 32'(bus.SELF_HIT), 1);
      checkHead("hit_head_held", 4, 3, 5);
      ticks = 0;
      repeat (12) begin
         stepCycle();
         if (bus.MOVE_TICK === 1'b1) ticks++;
      end
      checkOutput("no_tick_after_hit", ticks, 0);
      checkOutput("self_hit_sticky", 32'(bus.SELF_HIT), 1);

      // Reset clears the collision.
      rst = 1'b1;
      applyStimulus(1, 0, 0);
      stepCycle();
      rst = 1'b0;
      checkHead("hit_reset", 4, 4, 3);
      checkOutput("hit_reset_flag", 32'(bus.SELF_HIT), 0);

      // Back-to-back queries against the reset body.
      queryCheck(3, 4, 0, 1);
      queryCheck(4, 4, 1, 0);
      queryCheck(2, 4, 0, 1);
      queryCheck(1, 4, 0, 0);
      queryCheck(0, 4, 0, 0);
      queryCheck(5, 4, 0, 0);
      stepCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
